// File: rtl/adder_share_arbiter_pkg.sv
// Shared defaults, tag-width helper and pipeline occupancy encoding for adder_share_arbiter.
package adder_share_arbiter_pkg;

    localparam int unsigned WidthDefault = 40;
    localparam int unsigned NReqDefault  = 4;

    // Tag width for n requesters; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Pipeline occupancy as {s1_v, s2_v}.
    typedef enum logic [1:0] {
        PipeEmpty = 2'b00,
        PipeS2    = 2'b01,
        PipeS1    = 2'b10,
        PipeFull  = 2'b11
    } pipe_state_e;

endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping modulo N_REQ.
module adder_share_arbiter_rr_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = NReqDefault,
    parameter int unsigned ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    input  logic             enable_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  grant_idx_o,
    output logic             any_valid_o
);

    // Rotating priority search; grant_o is only asserted when enabled.
    always_comb begin
        logic [ID_W-1:0] idx;
        logic            found;
        found       = 1'b0;
        idx         = '0;
        grant_idx_o = '0;
        grant_o     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = ID_W'((32'(ptr_i) + i) % N_REQ);
            if (!found && req_i[idx]) begin
                found       = 1'b1;
                grant_idx_o = idx;
            end
        end
        if (enable_i && found) begin
            grant_o[grant_idx_o] = 1'b1;
        end
        any_valid_o = found;
    end

endmodule

// File: rtl/rca_adder.sv
// Plain WIDTH-bit ripple-carry adder; the carry-out is dropped (sum is modulo 2^WIDTH).
module rca_adder #(
    parameter int unsigned WIDTH = 40
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    // Ripple the carry from bit 0 upward.
    always_comb begin
        logic c;
        c     = 1'b0;
        sum_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// One shared ripple-carry adder behind a round-robin arbiter, with a two-stage tagged pipeline.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = NReqDefault,
    parameter int unsigned WIDTH = WidthDefault,
    parameter int unsigned ID_W  = id_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
);

    logic             s1_v_q, s1_v_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d;
    logic             s2_v_q, s2_v_d;
    logic [WIDTH-1:0] s2_sum_q, s2_sum_d;
    logic [ID_W-1:0]  s2_id_q, s2_id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;

    logic             s2_free, s1_adv, accept;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic             any_valid;
    logic [WIDTH-1:0] adder_sum;
    pipe_state_e      pipe_state;

    assign s2_free = !s2_v_q || rsp_ready;
    assign s1_adv  = s1_v_q && s2_free;
    assign accept  = !s1_v_q || s1_adv;

    adder_share_arbiter_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .enable_i    (accept && !rst),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_valid_o (any_valid)
    );

    rca_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i   (s1_a_q),
        .b_i   (s1_b_q),
        .sum_o (adder_sum)
    );

    // Next state: accept into stage 1, advance into stage 2, retire on rsp_ready.
    always_comb begin
        s1_v_d   = s1_v_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_id_d  = s1_id_q;
        s2_v_d   = s2_v_q;
        s2_sum_d = s2_sum_q;
        s2_id_d  = s2_id_q;
        ptr_d    = ptr_q;

        if (accept && any_valid) begin
            s1_v_d  = 1'b1;
            s1_a_d  = req_a[32'(grant_idx) * WIDTH +: WIDTH];
            s1_b_d  = req_b[32'(grant_idx) * WIDTH +: WIDTH];
            s1_id_d = grant_idx;
            ptr_d   = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end else if (s1_adv) begin
            s1_v_d = 1'b0;
        end

        if (s1_adv) begin
            s2_v_d   = 1'b1;
            s2_sum_d = adder_sum;
            s2_id_d  = s1_id_q;
        end else if (rsp_ready) begin
            s2_v_d = 1'b0;
        end
    end

    // Pipeline and pointer registers with synchronous reset; in-flight pairs are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_id_q  <= '0;
            s2_v_q   <= 1'b0;
            s2_sum_q <= '0;
            s2_id_q  <= '0;
            ptr_q    <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_id_q  <= s1_id_d;
            s2_v_q   <= s2_v_d;
            s2_sum_q <= s2_sum_d;
            s2_id_q  <= s2_id_d;
            ptr_q    <= ptr_d;
        end
    end

    assign pipe_state = pipe_state_e'({s1_v_q, s2_v_q});

    // Outputs; valid/busy are masked during reset so nothing stale leaks before the first edge.
    always_comb begin
        req_ready = grant;
        rsp_valid = !rst && s2_v_q;
        rsp_sum   = s2_sum_q;
        rsp_id    = s2_id_q;
        busy      = !rst && (pipe_state != PipeEmpty);
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: driver pushes expected responses, monitor pops them.
module tb_adder_share_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned WIDTH = 40;
    localparam int unsigned ID_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WIDTH-1:0]       rsp_sum;
    logic [ID_W-1:0]        rsp_id;
    logic                   busy;

    adder_share_arbiter #(
        .N_REQ (N_REQ),
        .WIDTH (WIDTH),
        .ID_W  (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] sum;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_valid[i]            = 1'b1;
    endtask

    // Check the grant pattern and, if a grant is expected, queue the expected response.
    task automatic expect_grant(input string name, input logic [N_REQ-1:0] exp_ready, input int g,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        #1;
        check(name, 64'(req_ready), 64'(exp_ready));
        if (exp_ready != '0) begin
            e.id  = ID_W'(g);
            e.sum = WIDTH'(a + b);
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 50) begin
            step();
            n++;
        end
        check({name, "_queue"}, 64'(sb.size()), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Monitor: compare every retired response; also require stability while stalled.
    logic             hold_v = 1'b0;
    logic [WIDTH-1:0] hold_sum;
    logic [ID_W-1:0]  hold_id;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && rsp_valid) begin
                check("hold_sum", 64'(rsp_sum), 64'(hold_sum));
                check("hold_id", 64'(rsp_id), 64'(hold_id));
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got id %0d sum 0x%0h, expected no response",
                             rsp_id, rsp_sum);
                end else begin
                    e = sb.pop_front();
                    check("rsp_sum", 64'(rsp_sum), 64'(e.sum));
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                end
            end
            hold_v   = rsp_valid && !rsp_ready;
            hold_sum = rsp_sum;
            hold_id  = rsp_id;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset behaviour
        repeat (2) step();
        req_valid = '1;
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        step();
        check("rst_sum", 64'(rsp_sum), 64'd0);
        check("rst_id", 64'(rsp_id), 64'd0);
        rst       = 1'b0;
        req_valid = '0;

        // Single request from requester 2: 5 + 7 = 0x0C
        step();
        offer(2, 40'h00_0000_0005, 40'h00_0000_0007);
        expect_grant("single_grant", 4'b0100, 2, 40'h00_0000_0005, 40'h00_0000_0007);
        step();
        req_valid = '0;
        check("single_busy_s1", 64'(busy), 64'd1);
        check("single_no_rsp_yet", 64'(rsp_valid), 64'd0);
        step();
        check("single_rsp_valid", 64'(rsp_valid), 64'd1);
        step();
        check("single_busy_after", 64'(busy), 64'd0);
        check("single_rsp_gone", 64'(rsp_valid), 64'd0);

        // Wrap-around: 0xFF_FFFF_FFFF + 1 = 0 (pointer is 3, only requester 1 asks)
        step();
        offer(1, 40'hFF_FFFF_FFFF, 40'h00_0000_0001);
        expect_grant("wrap_grant", 4'b0010, 1, 40'hFF_FFFF_FFFF, 40'h00_0000_0001);
        step();
        req_valid = '0;
        drain("wrap_drain");

        // Round-robin from ptr=0 with all four requesters held
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_a[i*WIDTH +: WIDTH] = 40'h00_1000_0000 * (i + 1);
            req_b[i*WIDTH +: WIDTH] = 40'h0F_0000_0001 + 40'(i);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            req_valid = '1;
            expect_grant("rr_grant", 4'(1 << (k % 4)), k % 4,
                         40'h00_1000_0000 * ((k % 4) + 1), 40'h0F_0000_0001 + 40'(k % 4));
            if (k >= 2) check("rr_rsp_back_to_back", 64'(rsp_valid), 64'd1);
        end
        step();
        req_valid = '0;
        drain("rr_drain");

        // Backpressure: two accepts fill the pipe, third waits until rsp_ready returns
        step();
        offer(1, 40'd1, 40'd2);
        expect_grant("bp_grant0", 4'b0010, 1, 40'd1, 40'd2);
        step();
        offer(1, 40'd3, 40'd4);
        expect_grant("bp_grant1", 4'b0010, 1, 40'd3, 40'd4);
        step();
        rsp_ready = 1'b0;
        offer(1, 40'd5, 40'd6);
        #1;
        check("bp_full_ready", 64'(req_ready), 64'd0);
        check("bp_full_busy", 64'(busy), 64'd1);
        check("bp_full_rsp_valid", 64'(rsp_valid), 64'd1);
        check("bp_full_sum", 64'(rsp_sum), 64'd3);
        for (int k = 0; k < 2; k++) begin
            step();
            check("bp_stall_ready", 64'(req_ready), 64'd0);
            check("bp_stall_sum", 64'(rsp_sum), 64'd3);
            check("bp_stall_id", 64'(rsp_id), 64'd1);
        end
        step();
        rsp_ready = 1'b1;
        expect_grant("bp_grant2", 4'b0010, 1, 40'd5, 40'd6);
        step();
        req_valid = '0;
        check("bp_rsp2_valid", 64'(rsp_valid), 64'd1);
        step();
        check("bp_rsp3_valid", 64'(rsp_valid), 64'd1);
        step();
        check("bp_done_valid", 64'(rsp_valid), 64'd0);
        drain("bp_drain");

        // Reset mid-flight while FULL
        rsp_ready = 1'b0;
        step();
        offer(2, 40'd10, 40'd20);
        expect_grant("rm_grant0", 4'b0100, 2, 40'd10, 40'd20);
        step();
        offer(2, 40'd30, 40'd40);
        expect_grant("rm_grant1", 4'b0100, 2, 40'd30, 40'd40);
        step();
        rst = 1'b1;
        sb.delete();
        #1;
        check("rm_rst_ready", 64'(req_ready), 64'd0);
        step();
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        check("rm_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rm_busy", 64'(busy), 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rm_no_stale", 64'(rsp_valid), 64'd0);
        end
        offer(0, 40'h12_3456_789A, 40'h01_0101_0101);
        offer(3, 40'h00_0000_00FF, 40'h00_0000_0001);
        expect_grant("rm_first_grant", 4'b0001, 0, 40'h12_3456_789A, 40'h01_0101_0101);
        step();
        req_valid = 4'b1000;
        expect_grant("rm_second_grant", 4'b1000, 3, 40'h00_0000_00FF, 40'h00_0000_0001);
        step();
        req_valid = '0;
        drain("rm_drain");

        // Sparse: requester 3 every other cycle, then ptr must have wrapped to 0
        for (int k = 0; k < 3; k++) begin
            step();
            offer(3, 40'd100 + 40'(k), 40'd200 + 40'(k));
            expect_grant("sp_grant", 4'b1000, 3, 40'd100 + 40'(k), 40'd200 + 40'(k));
            step();
            req_valid = '0;
        end
        step();
        offer(0, 40'h80_0000_0000, 40'h80_0000_0001);
        offer(3, 40'd7, 40'd9);
        expect_grant("sp_wrap_grant", 4'b0001, 0, 40'h80_0000_0000, 40'h80_0000_0001);
        step();
        req_valid = 4'b1000;
        expect_grant("sp_tail_grant", 4'b1000, 3, 40'd7, 40'd9);
        step();
        req_valid = '0;
        drain("final_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one WIDTH-bit ripple-carry adder between N_REQ independent requesters.
- Round-robin arbitration with a valid/ready handshake per requester.
- Two-stage pipeline: operand register, then result register. Tagged responses on a single output port with backpressure.
- Sits between the multiplier's partial-sum producers and the final accumulation path.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 40, operand and sum width in bits
- ID_W, $clog2(N_REQ), width of the requester tag

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  N_REQ  requester i has an operand pair
- req_ready  output  N_REQ  requester i's pair is accepted this cycle
- req_a  input  N_REQ*WIDTH  operand A; slice i belongs to requester i
- req_b  input  N_REQ*WIDTH  operand B; slice i belongs to requester i
- rsp_valid  output  1  rsp_sum and rsp_id are valid
- rsp_ready  input  1  consumer accepts the response
- rsp_sum  output  WIDTH  (A+B) mod 2^WIDTH
- rsp_id  output  ID_W  index of the requester that issued the pair
- busy  output  1  either pipeline stage occupied

Behaviour:
- Interface: one clock (clk); synchronous, active-high reset (rst).
- Reset:
  - On the clk edge with rst=1, clear both stage-valid flags and set the RR pointer to 0.
  - rsp_valid=0, busy=0, req_ready=0 while rst is high.
  - rsp_sum, rsp_id and the operand registers are cleared to 0.
- Reset mid-operation: in-flight pairs are discarded with no response. Requesters must re-present them.
- Pipeline state is the pair (s1_v, s2_v): EMPTY(0,0), S1(1,0), S2(0,1), FULL(1,1).
- Handshake timing:
  - Stage 2 can take data: s2_free = !s2_v | rsp_ready.
  - Stage 1 moves forward: s1_adv = s1_v & s2_free.
  - New pair accepted: accept = !s1_v | s1_adv.
- Arbitration (combinational):
  - Grant goes to the first requester with req_valid=1, searching from index ptr upward and wrapping modulo N_REQ.
  - req_ready[g] = accept & req_valid[g]; every other bit of req_ready is 0.
  - At most one bit of req_ready is high in any cycle.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- On accept with any valid request:
  - Latch req_a[g], req_b[g] and g into stage 1; set s1_v=1.
  - Set ptr = (g+1) mod N_REQ.
- With no valid request, ptr holds.
- If stage 1 advances and no new pair arrives, s1_v=0.
- When stage 1 advances, stage 2 latches the adder output (sum of the stage-1 operands) and the stage-1 tag, and s2_v=1.
- If rsp_ready=1 and stage 1 does not advance, s2_v=0.
- rsp_valid = s2_v, and rsp_sum/rsp_id come straight from the stage-2 registers.
- Response stability: while rsp_valid=1 and rsp_ready=0, rsp_sum and rsp_id hold.
- Latency: a pair accepted on edge E0 appears with rsp_valid=1 after edge E1, assuming no backpressure.
- Throughput: one pair per cycle while rsp_ready=1.
- Full pipeline (FULL) with rsp_ready=0: accept=0 and all req_ready=0.
- Same-cycle accept and retire in FULL: if rsp_ready=1, the response retires, stage 1 moves to stage 2 and a new pair is accepted, all in one cycle.
- Arithmetic: unsigned, modulo 2^WIDTH. The carry-out is discarded and there is no overflow flag.
- Fairness: a continuously asserted requester is granted within N_REQ accepts.
- busy = s1_v | s2_v.

Decomposition:
- Shared package holds: the WIDTH default (40), the N_REQ default, the ID_W derivation function, and the pipeline state encoding constants.
- One sub-module, rr_arbiter:
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant, grant index, any_valid.
  - Contains no registers; the pointer lives in the top level.
- The adder is the codebase's existing WIDTH-bit ripple-carry adder, instantiated as-is between stage 1 and stage 2.

Test Plan:
- Single request: rst 2 cycles, then req_valid[2]=1 with A=0x00_0000_0005, B=0x00_0000_0007 for one cycle.
  - Expected: req_ready[2]=1 on the accept cycle.
  - Expected: rsp_valid=1 after the next edge with rsp_sum=0x0C, rsp_id=2, busy=0 one cycle after retire.
- Wrap-around: A=0xFF_FFFF_FFFF, B=0x00_0000_0001.
  - Expected: rsp_sum=0x00_0000_0000, no other side effect.
- Round-robin: all four req_valid held high, rsp_ready=1, ptr=0.
  - Expected: grant order 0,1,2,3,0; rsp_id sequence 0,1,2,3 on consecutive cycles.
- Backpressure: stream 3 pairs with rsp_ready=0 from the cycle of the first response.
  - Expected: FULL after 2 accepts; third req_ready=0; rsp_sum held stable.
  - Then raise rsp_ready: expect 3 responses on consecutive cycles, in order.
- Reset mid-flight: accept 2 pairs, assert rst while FULL.
  - Expected: next cycle rsp_valid=0, busy=0, no stale response afterwards.
  - A subsequent request from requester 0 is granted first.
- Sparse requests: only req_valid[3] toggles every other cycle.
  - Expected: each pair is granted immediately and ptr wraps to 0 after each grant.
